// File: rtl/adder_slice_sched.sv
// adder_slice_sched: time-shares one 2-bit ripple-adder slice between two
// requesters. Each WIDTH-bit add runs serially, two bits per cycle, with a
// registered carry chained between slices. Grants alternate round-robin.
module adder_slice_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0_in,
  input  logic [WIDTH-1:0] b0_in,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1_in,
  input  logic [WIDTH-1:0] b1_in,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int NSLICE = WIDTH / 2;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  // Odd or too-small widths cannot be split into 2-bit slices.
  if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_width_chk
    $error("adder_slice_sched: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The shared 2-bit slice: {c, s1, s0} = a + b + cin.
  function automatic logic [2:0] slice_add(input logic [1:0] a,
                                           input logic [1:0] b,
                                           input logic       cin);
    return {1'b0, a} + {1'b0, b} + {2'b00, cin};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             own_q, own_d;
  logic             ptr_q, ptr_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [2:0]       slice_s;
  logic [WIDTH-1:0] res_next_s;
  logic             win_s;

  // Next-state, datapath and output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    owner_d = owner_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    slice_s    = slice_add(a_q[1:0], b_q[1:0], cy_q);
    // New slice bits enter at the MSB end; after NSLICE shifts the result is aligned.
    res_next_s = WIDTH'({slice_s[1:0], res_q} >> 2);
    // Lone requester wins; on contention the pointer picks who did not win last.
    if (req0 && req1) begin
      win_s = ptr_q;
    end else begin
      win_s = req1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (req0 || req1) begin
          a_d     = win_s ? a1_in : a0_in;
          b_d     = win_s ? b1_in : b0_in;
          res_d   = '0;
          cy_d    = 1'b0;
          cnt_d   = '0;
          own_d   = win_s;
          ptr_d   = ~win_s;
          gnt0_d  = ~win_s;
          gnt1_d  = win_s;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> 2;
        b_d   = b_q >> 2;
        res_d = res_next_s;
        cy_d  = slice_s[2];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_next_s;
          cout_d  = slice_s[2];
          owner_d = own_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      own_q   <= 1'b0;
      ptr_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      owner_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign owner     = owner_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule
